// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned IDW    = 3;
    localparam int unsigned HOLD_W = 5;

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority pick: lowest requester index at or after ptr, in circular order.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;

    // Bit j of w_rot is req[(j + ptr) mod N], so bit 0 is the current pointer.
    assign w_rot = N'({req, req} >> ptr);
    assign any   = |req;

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
            end
        end
    end

    assign idx = w_off + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant held until the owner drops req.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
    parameter int unsigned N        = arb_pkg::N,
    parameter int unsigned IDW      = arb_pkg::IDW,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    output logic [N-1:0]              grant,
    output logic [IDW-1:0]            grant_id,
    output logic                      grant_valid,
    output logic [arb_pkg::HOLD_W-1:0] hold_cnt,
    output logic                      timeout
);

    import arb_pkg::*;

    if (N != 8 || IDW != 3 || MAX_HOLD < 1 || MAX_HOLD > 32) begin : g_bad_cfg
        $error("rr_arbiter8: unsupported configuration");
    end

    localparam logic [HOLD_W-1:0] HoldSat = '1;

    state_e            r_state, w_state_d;
    logic [N-1:0]      r_grant, w_grant_d;
    logic [IDW-1:0]    r_grant_id, w_grant_id_d;
    logic [IDW-1:0]    r_ptr, w_ptr_d;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_d;
    logic              w_any;
    logic [IDW-1:0]    w_idx;
`ifdef ARB_TIMEOUT_EN
    logic              r_timeout, w_timeout_d;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        w_state_d    = r_state;
        w_grant_d    = r_grant;
        w_grant_id_d = r_grant_id;
        w_ptr_d      = r_ptr;
        w_hold_cnt_d = r_hold_cnt;
`ifdef ARB_TIMEOUT_EN
        w_timeout_d  = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_d    = StGrant;
                    w_grant_d    = N'(1) << w_idx;
                    w_grant_id_d = w_idx;
                    w_hold_cnt_d = '0;
                end
            end
            StGrant: begin
                // Only the owner's request bit matters here; no preemption.
                if (!req[r_grant_id]) begin
                    w_state_d    = StIdle;
                    w_grant_d    = '0;
                    w_hold_cnt_d = '0;
                    w_ptr_d      = r_grant_id + IDW'(1);
`ifdef ARB_TIMEOUT_EN
                end else if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    w_state_d    = StIdle;
                    w_grant_d    = '0;
                    w_hold_cnt_d = '0;
                    w_ptr_d      = r_grant_id + IDW'(1);
                    w_timeout_d  = 1'b1;
`endif
                end else if (r_hold_cnt != HoldSat) begin
                    w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_grant    <= w_grant_d;
            r_grant_id <= w_grant_id_d;
            r_ptr      <= w_ptr_d;
            r_hold_cnt <= w_hold_cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_d;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = |r_grant;
    assign hold_cnt    = r_hold_cnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, saturation/timeout, round-robin, async reset.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned MH = 4;
`else
    localparam int unsigned MH = 16;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic [4:0] hold_cnt;
    logic       timeout;

    rr_arbiter8 #(
        .N        (8),
        .IDW      (3),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .hold_cnt    (hold_cnt),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic [4:0] hold;
        logic       to;
    } out_t;

    typedef struct packed {
        logic [7:0] req;
        out_t       exp;
    } vec_t;

    out_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic out_t mk(logic [7:0] g, logic [2:0] id, logic [4:0] h, logic to);
        out_t o;
        o.grant = g;
        o.id    = (g != 8'h00) ? id : 3'd0;
        o.valid = (g != 8'h00);
        o.hold  = h;
        o.to    = to;
        return o;
    endfunction

    function automatic vec_t mv(logic [7:0] r, out_t e);
        vec_t v;
        v.req = r;
        v.exp = e;
        return v;
    endfunction

    task automatic compare(input string name, input out_t exp);
        out_t act;
        act.grant = grant;
        act.id    = grant_valid ? grant_id : 3'd0;
        act.valid = grant_valid;
        act.hold  = hold_cnt;
        act.to    = timeout;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%h id=%0d valid=%b hold=%0d timeout=%b, want grant=%h id=%0d valid=%b hold=%0d timeout=%b",
                     name, act.grant, act.id, act.valid, act.hold, act.to,
                     exp.grant, exp.id, exp.valid, exp.hold, exp.to);
        end
    endtask

    // Drive req at the falling edge, compare the registered result just after the rising edge.
    task automatic step(input string name, input logic [7:0] r, input out_t exp);
        out_t e;
        @(negedge clk);
        req = r;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(name, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b0;
        #1;
        compare("reset_assert", mk(8'h00, 3'd0, 5'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] all_but;
        logic [4:0] h;

        // Power-on: outputs must clear as soon as rst_n falls, before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        compare("reset_initial", mk(8'h00, 3'd0, 5'd0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ptr starts at 0; comments give ptr after each release.
        for (int i = 0; i < 5; i++) tbl.push_back(mv(8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0)));
        tbl.push_back(mv(8'h20, mk(8'h20, 3'd5, 5'd0, 1'b0)));
        tbl.push_back(mv(8'h20, mk(8'h20, 3'd5, 5'd1, 1'b0)));
        tbl.push_back(mv(8'h20, mk(8'h20, 3'd5, 5'd2, 1'b0)));
        tbl.push_back(mv(8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=6
        tbl.push_back(mv(8'h03, mk(8'h01, 3'd0, 5'd0, 1'b0)));  // wrap 6,7,0
        tbl.push_back(mv(8'h03, mk(8'h01, 3'd0, 5'd1, 1'b0)));
        tbl.push_back(mv(8'h02, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=1
        tbl.push_back(mv(8'h83, mk(8'h02, 3'd1, 5'd0, 1'b0)));
        tbl.push_back(mv(8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=2
        tbl.push_back(mv(8'hFF, mk(8'h04, 3'd2, 5'd0, 1'b0)));
        tbl.push_back(mv(8'hFF, mk(8'h04, 3'd2, 5'd1, 1'b0)));  // others ignored
        tbl.push_back(mv(8'hFB, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=3
        tbl.push_back(mv(8'hFB, mk(8'h08, 3'd3, 5'd0, 1'b0)));
        tbl.push_back(mv(8'hF3, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=4
        tbl.push_back(mv(8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0)));
        tbl.push_back(mv(8'h11, mk(8'h10, 3'd4, 5'd0, 1'b0)));
        tbl.push_back(mv(8'h01, mk(8'h00, 3'd0, 5'd0, 1'b0)));  // ptr=5
        tbl.push_back(mv(8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0)));

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].exp);
        end

        // ptr=5, only requester 0 asks.
        step("long_grant", 8'h01, mk(8'h01, 3'd0, 5'd0, 1'b0));
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 4; k++) step("to_hold", 8'h01, mk(8'h01, 3'd0, 5'(k), 1'b0));
        step("to_force", 8'h01, mk(8'h00, 3'd0, 5'd0, 1'b1));
        step("to_regrant", 8'h01, mk(8'h01, 3'd0, 5'd0, 1'b0));
        for (int k = 1; k < 4; k++) step("to_hold2", 8'h03, mk(8'h01, 3'd0, 5'(k), 1'b0));
        step("to_force2", 8'h03, mk(8'h00, 3'd0, 5'd0, 1'b1));
        step("to_next", 8'h03, mk(8'h02, 3'd1, 5'd0, 1'b0));
        step("to_drop", 8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0));
`else
        for (int k = 1; k <= 40; k++) begin
            h = (k > 31) ? 5'd31 : 5'(k);
            step($sformatf("hold_sat%0d", k), 8'h01, mk(8'h01, 3'd0, h, 1'b0));
        end
        step("long_drop", 8'h00, mk(8'h00, 3'd0, 5'd0, 1'b0));
`endif

        // All requesting; each owner drops for one cycle after two granted cycles.
        do_reset();
        for (int n = 0; n < 9; n++) begin
            all_but = ~(8'h01 << (n % 8));
            step($sformatf("rr_grant%0d", n), 8'hFF, mk(8'h01 << (n % 8), 3'(n % 8), 5'd0, 1'b0));
            step($sformatf("rr_hold%0d", n), 8'hFF, mk(8'h01 << (n % 8), 3'(n % 8), 5'd1, 1'b0));
            step($sformatf("rr_bubble%0d", n), all_but, mk(8'h00, 3'd0, 5'd0, 1'b0));
        end

        // ptr=1 here; grant 3, then reset mid-cycle while it is held.
        step("mid_grant", 8'h08, mk(8'h08, 3'd3, 5'd0, 1'b0));
        step("mid_hold", 8'h08, mk(8'h08, 3'd3, 5'd1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        compare("reset_async", mk(8'h00, 3'd0, 5'd0, 1'b0));
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        // ptr must be back at 0: requesters 0 and 3 both ask, 0 wins.
        step("post_reset", 8'h09, mk(8'h01, 3'd0, 5'd0, 1'b0));
        step("post_reset_rel", 8'h08, mk(8'h00, 3'd0, 5'd0, 1'b0));
        step("post_reset_3", 8'h08, mk(8'h08, 3'd3, 5'd0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- Combinational core: a rotated 8-to-3 priority pick (lowest index at/after pointer wins).
- Registered control: grant register, rotating pointer, hold counter.
- Sits in front of any shared single-port unit; the grant is held until the owner drops its request.

Parameters:
- N, 8, number of requesters (design verified only at 8)
- IDW, 3, width of grant_id (log2 N)
- MAX_HOLD, 16, max cycles a grant may be held; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request vector, level-sensitive; bit i = requester i
- grant  out  8  one-hot grant, registered; all-zero when no owner
- grant_id  out  3  binary index of owner; valid only when grant_valid=1
- grant_valid  out  1  high while a grant is held (equals |grant)
- hold_cnt  out  5  cycles the current grant has been held, saturating at 31
- timeout  out  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Interface decisions:
- One clock.
- Reset is asynchronous and active-low, on clk and rst_n.

Behaviour:
- Reset (async, any time, including mid-grant):
  - grant=0, grant_id=0, grant_valid=0, hold_cnt=0, timeout=0.
  - ptr=0, state=IDLE.
  - Outputs clear immediately on rst_n low, not at the next edge.
- State IDLE:
  - If req==0: stay IDLE, outputs 0.
  - Else pick w = first index in circular order ptr, ptr+1, ..., ptr+7 (mod 8) with req[w]=1.
  - Next edge: grant=1<<w, grant_id=w, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency req -> grant is 1 cycle.
- State GRANT:
  - While req[grant_id]=1: hold the grant. hold_cnt increments each edge and saturates at 31.
  - Other req bits are ignored; no preemption.
  - Release when req[grant_id]=0 is sampled. Next edge: grant=0, grant_valid=0, hold_cnt=0, ptr=(grant_id+1) mod 8 (7 wraps to 0), state=IDLE.
- Bubble: at least one idle cycle between consecutive grants. A back-to-back handoff costs exactly 1 cycle of grant_valid=0.
- Fairness: after requester i releases, it has lowest priority. With all 8 requesting continuously, grants go ptr, ptr+1, ... with no starvation.
- A requester re-asserting req in the release cycle is considered only from IDLE, at lowest priority.
- grant is always one-hot or zero; grant_id must equal the encoded grant whenever grant_valid=1.
- pick logic is pure combinational from req and ptr; all outputs come from flops.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1 and req[grant_id] is still 1, force release at the next edge.
  - Forced release: grant=0, ptr=grant_id+1, state=IDLE, timeout=1 for that one cycle.
  - The timed-out requester may win again later under normal round-robin.
  - A normal release in the same cycle takes precedence: timeout=0.
- Undefined:
  - Grants are unbounded; timeout is tied 0.
  - MAX_HOLD is unused.

Decomposition:
- Package arb_pkg:
  - N, IDW, HOLD_W=5 constants.
  - State enum {IDLE, GRANT}.
- Sub-module rr_pick (combinational): inputs req[7:0] and ptr[2:0]; outputs any and idx[2:0]. It rotates req right by ptr, priority-encodes from the lowest bit, then adds ptr mod 8.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 5 cycles -> all outputs 0.
- Single requester: req=8'b0010_0000 -> next cycle grant=8'h20, grant_id=5, hold_cnt=0,1,2...; drop req -> grant=0 next cycle, ptr=6.
- Round-robin: req=8'hFF held, each owner drops its req for 1 cycle after 2 cycles of grant -> grant_id sequence 0,1,2,...,7,0 with one bubble cycle between grants.
- Wrap/priority: ptr=6 (after releasing id 5), req=8'b0000_0011 -> grant_id=0. Then ptr=1, req=8'b1000_0011 -> grant_id=1.
- Reset mid-grant: grant_id=3 held, rst_n pulsed low mid-cycle -> grant=0 immediately; after reset, req=8'h08 -> grant_id=3 (ptr=0 path).
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=8'h01 held -> grant for 4 cycles, timeout=1 on release edge, 1 idle cycle, then regrant to id 0. Other req=8'h02 also present -> grant_id=1 instead.
